dispatch: RTL and testbench

Dispatch stage between rename and the issue stage. Holds one renamed bundle of up to PIPE_WIDTH instructions and routes each one, in program order, to the ALU RS, the load LSQ or the store LSQ. It uses the per-lane ready/write-enable handshake that the issue stage exposes. Held instructions snoop the CDB so that no wakeup is lost while they wait.

---
 rtl/dispatch.sv | 148 ++++++++++++++
 tb/tb_dispatch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dispatch.sv
// Dispatch stage: holds one renamed bundle and routes each slot in program order
// to the ALU RS or the load/store LSQ lanes, forwarding CDB results into waiting operands.

package uarch_pkg;
  localparam int unsigned PIPE_WIDTH = 2;
  localparam int unsigned NUM_RS     = 3;
  localparam int unsigned TAG_WIDTH  = 6;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPC_W      = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OP_LW  = 4'd2;
  localparam logic [OPC_W-1:0] OP_SW  = 4'd3;

  typedef struct packed {
    logic                 rdy;
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      val;
  } operand_t;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [TAG_WIDTH-1:0] dest_tag;
    operand_t             src1;
    operand_t             src2;
  } instruction_t;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
  } writeback_packet_t;
endpackage

module dispatch
  import uarch_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  instruction_t [PIPE_WIDTH-1:0]            rename_insts,
  input  logic [PIPE_WIDTH-1:0]                    rename_vals,
  output logic                                     dispatch_rdy,
  input  logic [NUM_RS-1:0][PIPE_WIDTH-1:0]        rs_rdys,
  output logic [NUM_RS-1:0][PIPE_WIDTH-1:0]        rs_wes,
  output instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0] rs_issue_ports,
  input  writeback_packet_t [PIPE_WIDTH-1:0]       cdb_ports
);

  localparam int unsigned LANE_W = (PIPE_WIDTH > 1) ? $clog2(PIPE_WIDTH) : 1;
  localparam int unsigned CNT_W  = $clog2(PIPE_WIDTH + 1);
  localparam int unsigned RS_W   = $clog2(NUM_RS);

  localparam logic [RS_W-1:0] RS_ALU = RS_W'(0);
  localparam logic [RS_W-1:0] RS_LD  = RS_W'(1);
  localparam logic [RS_W-1:0] RS_ST  = RS_W'(2);

  instruction_t [PIPE_WIDTH-1:0] buf_q, buf_d, buf_fwd, in_fwd;
  logic [PIPE_WIDTH-1:0]         buf_v_q, buf_v_d, grant;

  function automatic operand_t fwd_op(input operand_t op,
                                      input writeback_packet_t [PIPE_WIDTH-1:0] cdb);
    operand_t r;
    r = op;
    for (int p = 0; p < PIPE_WIDTH; p++) begin
      if (!r.rdy && cdb[p].is_valid && (cdb[p].dest_tag == r.tag)) begin
        r.rdy = 1'b1;
        r.val = cdb[p].result;
      end
    end
    return r;
  endfunction

  function automatic instruction_t fwd_inst(input instruction_t inst,
                                            input writeback_packet_t [PIPE_WIDTH-1:0] cdb);
    instruction_t r;
    r      = inst;
    r.src1 = fwd_op(inst.src1, cdb);
    r.src2 = fwd_op(inst.src2, cdb);
    return r;
  endfunction

  function automatic logic [RS_W-1:0] rs_class(input logic [OPC_W-1:0] opc);
    logic [RS_W-1:0] c;
    c = RS_ALU;
    if (opc == OP_LW) c = RS_LD;
    else if (opc == OP_SW) c = RS_ST;
    return c;
  endfunction

  // CDB snoop on both the held bundle and the incoming bundle
  always_comb begin
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      buf_fwd[i] = fwd_inst(buf_q[i], cdb_ports);
      in_fwd[i]  = fwd_inst(rename_insts[i], cdb_ports);
    end
  end

  // In-order grant: each class packs its granted slots onto lanes 0,1,... ; first miss blocks younger slots
  always_comb begin
    logic                              blocked;
    logic [RS_W-1:0]                   cls;
    logic [NUM_RS-1:0][CNT_W-1:0]      cnt;
    rs_wes         = '0;
    rs_issue_ports = '0;
    grant          = '0;
    blocked        = 1'b0;
    cls            = RS_ALU;
    cnt            = '0;
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      if (buf_v_q[i] && !blocked) begin
        cls = rs_class(buf_q[i].opcode);
        if (rs_rdys[cls][LANE_W'(cnt[cls])]) begin
          grant[i]                                  = 1'b1;
          rs_wes[cls][LANE_W'(cnt[cls])]            = 1'b1;
          rs_issue_ports[cls][LANE_W'(cnt[cls])]    = buf_fwd[i];
          cnt[cls]                                  = cnt[cls] + CNT_W'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end
    dispatch_rdy = !blocked;
  end

  always_comb begin
    buf_d   = buf_fwd;
    buf_v_d = buf_v_q & ~grant;
    if (flush) begin
      buf_v_d = '0;
    end else if (dispatch_rdy) begin
      buf_d   = in_fwd;
      buf_v_d = rename_vals;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      buf_v_q <= '0;
    end else begin
      buf_q   <= buf_d;
      buf_v_q <= buf_v_d;
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: in-order grant, partial dispatch, CDB forwarding, flush, reset.

module tb_dispatch;
  import uarch_pkg::*;

  logic                                      clk;
  logic                                      rst;
  logic                                      flush;
  instruction_t [PIPE_WIDTH-1:0]             rename_insts;
  logic [PIPE_WIDTH-1:0]                     rename_vals;
  logic                                      dispatch_rdy;
  logic [NUM_RS-1:0][PIPE_WIDTH-1:0]         rs_rdys;
  logic [NUM_RS-1:0][PIPE_WIDTH-1:0]         rs_wes;
  instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0] rs_issue_ports;
  writeback_packet_t [PIPE_WIDTH-1:0]        cdb_ports;

  int n_checks = 0;
  int n_errors = 0;

  dispatch dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .rename_insts  (rename_insts),
    .rename_vals   (rename_vals),
    .dispatch_rdy  (dispatch_rdy),
    .rs_rdys       (rs_rdys),
    .rs_wes        (rs_wes),
    .rs_issue_ports(rs_issue_ports),
    .cdb_ports     (cdb_ports)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instruction_t mk(input logic [OPC_W-1:0] opc, input logic [TAG_WIDTH-1:0] dst,
                                      input logic [TAG_WIDTH-1:0] t1, input logic r1, input logic [XLEN-1:0] v1,
                                      input logic [TAG_WIDTH-1:0] t2, input logic r2, input logic [XLEN-1:0] v2);
    instruction_t x;
    x.opcode   = opc;
    x.dest_tag = dst;
    x.src1     = {r1, t1, v1};
    x.src2     = {r2, t2, v2};
    return x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  instruction_t i_add, i_sub, i_lw, i_sw, i_add5, e_add5, i_add57, e_add57;

  initial begin
    i_add   = mk(OP_ADD, 6'd1, 6'd10, 1'b1, 32'h11, 6'd11, 1'b1, 32'h22);
    i_sub   = mk(OP_SUB, 6'd2, 6'd12, 1'b1, 32'h33, 6'd13, 1'b1, 32'h44);
    i_lw    = mk(OP_LW,  6'd3, 6'd14, 1'b1, 32'h100, 6'd0, 1'b1, 32'h0);
    i_sw    = mk(OP_SW,  6'd4, 6'd15, 1'b1, 32'h200, 6'd16, 1'b1, 32'h55);
    i_add5  = mk(OP_ADD, 6'd8, 6'd5, 1'b0, 32'h0, 6'd17, 1'b1, 32'h66);
    e_add5  = mk(OP_ADD, 6'd8, 6'd5, 1'b1, 32'hDEAD, 6'd17, 1'b1, 32'h66);
    i_add57 = mk(OP_ADD, 6'd9, 6'd5, 1'b0, 32'h0, 6'd7, 1'b0, 32'h0);
    e_add57 = mk(OP_ADD, 6'd9, 6'd5, 1'b1, 32'hDEAD, 6'd7, 1'b1, 32'h1234);

    // reset
    rst = 1'b0; flush = 1'b0; rename_insts = '0; rename_vals = '0;
    rs_rdys = '1; cdb_ports = '0;
    #1;
    chk("reset_wes", 128'(rs_wes), 128'(6'b000000));
    chk("reset_rdy", 128'(dispatch_rdy), 128'(1'b1));
    chk("reset_port", 128'(rs_issue_ports), 128'(0));
    step();
    rst = 1'b1;

    // {ADD, SUB}, full throughput
    rename_insts[0] = i_add; rename_insts[1] = i_sub; rename_vals = 2'b11;
    #1;
    chk("no_comb_path_wes", 128'(rs_wes), 128'(6'b000000));
    step();
    rename_vals = 2'b00;
    #1;
    chk("addsub_wes", 128'(rs_wes), 128'(6'b000011));
    chk("addsub_lane0", 128'(rs_issue_ports[0][0]), 128'(i_add));
    chk("addsub_lane1", 128'(rs_issue_ports[0][1]), 128'(i_sub));
    chk("addsub_rdy", 128'(dispatch_rdy), 128'(1'b1));
    step();

    // {LW, SW}: partial dispatch
    rename_insts[0] = i_lw; rename_insts[1] = i_sw; rename_vals = 2'b11;
    step();
    rs_rdys = {2'b00, 2'b01, 2'b11};
    rename_insts[0] = i_add; rename_insts[1] = i_sub; rename_vals = 2'b11;
    #1;
    chk("lwsw_wes", 128'(rs_wes), 128'(6'b000100));
    chk("lwsw_lw_port", 128'(rs_issue_ports[1][0]), 128'(i_lw));
    chk("lwsw_st_idle", 128'(rs_issue_ports[2][0]), 128'(0));
    chk("lwsw_rdy", 128'(dispatch_rdy), 128'(1'b0));
    step();
    rs_rdys = {2'b01, 2'b01, 2'b11};
    rename_vals = 2'b00;
    #1;
    chk("sw_retry_wes", 128'(rs_wes), 128'(6'b010000));
    chk("sw_retry_port", 128'(rs_issue_ports[2][0]), 128'(i_sw));
    chk("sw_retry_rdy", 128'(dispatch_rdy), 128'(1'b1));
    step();

    // {ADD(tag5 pending), LW}: in-order block, CDB hit while held
    rs_rdys = '1;
    rename_insts[0] = i_add5; rename_insts[1] = i_lw; rename_vals = 2'b11;
    step();
    rs_rdys = {2'b11, 2'b11, 2'b00};
    cdb_ports[1] = {1'b1, 6'd5, 32'hDEAD};
    rename_insts[0] = i_sub; rename_insts[1] = i_sub; rename_vals = 2'b11;
    #1;
    chk("block_wes", 128'(rs_wes), 128'(6'b000000));
    chk("block_rdy", 128'(dispatch_rdy), 128'(1'b0));
    step();
    cdb_ports = '0;
    #1;
    chk("block2_wes", 128'(rs_wes), 128'(6'b000000));
    step();
    rs_rdys = '1;
    rename_vals = 2'b00;
    #1;
    chk("held_fwd_wes", 128'(rs_wes), 128'(6'b000101));
    chk("held_fwd_alu", 128'(rs_issue_ports[0][0]), 128'(e_add5));
    chk("held_fwd_lw", 128'(rs_issue_ports[1][0]), 128'(i_lw));
    chk("held_fwd_rdy", 128'(dispatch_rdy), 128'(1'b1));
    step();

    // capture-time forwarding of src2, grant-cycle forwarding of src1
    rename_insts[0] = i_add57; rename_insts[1] = i_sw; rename_vals = 2'b01;
    cdb_ports[0] = {1'b1, 6'd7, 32'h1234};
    step();
    cdb_ports = '0;
    cdb_ports[1] = {1'b1, 6'd5, 32'hDEAD};
    rename_vals = 2'b00;
    #1;
    chk("grant_fwd_wes", 128'(rs_wes), 128'(6'b000001));
    chk("grant_fwd_port", 128'(rs_issue_ports[0][0]), 128'(e_add57));
    step();
    cdb_ports = '0;

    // flush of a stalled buffer
    rename_insts[0] = i_add; rename_insts[1] = i_sub; rename_vals = 2'b11;
    rs_rdys = {2'b11, 2'b11, 2'b00};
    step();
    flush = 1'b1;
    rename_insts[0] = i_lw; rename_insts[1] = i_sw; rename_vals = 2'b11;
    #1;
    chk("flush_cycle_rdy", 128'(dispatch_rdy), 128'(1'b0));
    step();
    flush = 1'b0;
    rs_rdys = '1;
    rename_vals = 2'b00;
    #1;
    chk("post_flush_wes", 128'(rs_wes), 128'(6'b000000));
    chk("post_flush_rdy", 128'(dispatch_rdy), 128'(1'b1));
    step();

    // reset asserted mid-stall
    rename_insts[0] = i_add; rename_insts[1] = i_sub; rename_vals = 2'b11;
    rs_rdys = {2'b11, 2'b11, 2'b00};
    step();
    rename_vals = 2'b00;
    #1;
    chk("stall_pre_rst_wes", 128'(rs_wes), 128'(6'b000000));
    chk("stall_pre_rst_rdy", 128'(dispatch_rdy), 128'(1'b0));
    rs_rdys = '1;
    rst = 1'b0;
    #1;
    chk("rst_async_wes", 128'(rs_wes), 128'(6'b000000));
    chk("rst_async_rdy", 128'(dispatch_rdy), 128'(1'b1));
    step();
    rst = 1'b1;
    #1;
    chk("rst_release_wes", 128'(rs_wes), 128'(6'b000000));
    step();
    chk("rst_idle_wes", 128'(rs_wes), 128'(6'b000000));
    chk("rst_idle_rdy", 128'(dispatch_rdy), 128'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
